// File: rtl/io_bus_decoder.sv
// io_bus_decoder
//
// Address decoder for the core data bus. Each load/store is routed to RAM
// (addr[IO_SEL_BIT]=0) or to one of N_SLOTS memory-mapped peripheral slots
// (addr[IO_SEL_BIT]=1, slot = addr[IO_SEL_BIT-1:SLOT_SHIFT]). IO accesses
// take WAIT_CYC wait states, during which the core is stalled and the slot
// and direction are taken from a latched copy of the request.
//
// Optional feature macro: IO_BUS_ERR_EN
//   defined   : unmapped IO accesses set a sticky bus_err and record the
//               first faulting address in fault_addr (cleared by err_clr).
//   undefined : bus_err / fault_addr are tied to 0, err_clr is ignored.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   addr, we, re  core access (write wins when both we and re are set)
//   err_clr       synchronous clear of the sticky bus error
//   ram_rdata     RAM read data
//   io_rdata      per-slot read data, slot k at [k*DATA_W +: DATA_W]
//   ram_addr      address to RAM (same as addr)
//   ram_we        RAM write enable
//   io_sel        one-hot slot select for the whole IO access
//   io_we         one-hot slot write strobe, completion cycle only
//   io_off        register offset inside the slot
//   rdata         load data to the core
//   stall         core hold while an IO access is pending
//   bus_err       sticky unmapped-access flag
//   fault_addr    address of the first unmapped access
module io_bus_decoder #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int N_SLOTS    = 4,
    parameter int IO_SEL_BIT = 22,
    parameter int SLOT_SHIFT = 4,
    parameter int WAIT_CYC   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        we,
    input  logic                        re,
    input  logic                        err_clr,
    input  logic [DATA_W-1:0]           ram_rdata,
    input  logic [N_SLOTS*DATA_W-1:0]   io_rdata,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic                        ram_we,
    output logic [N_SLOTS-1:0]          io_sel,
    output logic [N_SLOTS-1:0]          io_we,
    output logic [SLOT_SHIFT-1:0]       io_off,
    output logic [DATA_W-1:0]           rdata,
    output logic                        stall,
    output logic                        bus_err,
    output logic [ADDR_W-1:0]           fault_addr
);

    localparam int SLOT_W = IO_SEL_BIT - SLOT_SHIFT;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q;
    logic                we_q;

    logic                req_we, req_re, req;
    logic                is_io, mapped, io_req, unmapped_req;
    logic [SLOT_W-1:0]   slot_num;

    function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        logic [N_SLOTS-1:0] oh;
        oh = '0;
        for (int k = 0; k < N_SLOTS; k++)
            if (s == SLOT_W'(k)) oh[k] = 1'b1;
        return oh;
    endfunction

    function automatic logic [DATA_W-1:0] slot_rdata(input logic [SLOT_W-1:0] s);
        logic [DATA_W-1:0] d;
        d = '0;
        for (int k = 0; k < N_SLOTS; k++)
            if (s == SLOT_W'(k)) d = io_rdata[k*DATA_W +: DATA_W];
        return d;
    endfunction

    // Requests are masked while reset is held so that stall and the strobes
    // drop immediately with rst even if the core keeps driving we/re.
    assign req_we       = we & ~rst;
    assign req_re       = re & ~rst;
    assign req          = req_we | req_re;
    assign is_io        = addr[IO_SEL_BIT];
    assign slot_num     = addr[IO_SEL_BIT-1:SLOT_SHIFT];
    assign mapped       = slot_num < SLOT_W'(N_SLOTS);
    assign io_req       = (state_q == ST_IDLE) & req & is_io & mapped;
    assign unmapped_req = (state_q == ST_IDLE) & req & is_io & ~mapped;

    assign ram_addr = addr;
    assign io_off   = addr[SLOT_SHIFT-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture; only consumed while in ST_WAIT, so no reset needed.
    always_ff @(posedge clk) begin
        if (io_req) begin
            slot_q <= slot_num;
            we_q   <= req_we;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (io_req && (WAIT_CYC != 0)) begin
                    state_d = ST_WAIT;
                    cnt_d   = 4'(WAIT_CYC - 1);
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                else               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        logic [N_SLOTS-1:0] sel_oh;
        sel_oh = '0;
        ram_we = 1'b0;
        io_sel = '0;
        io_we  = '0;
        rdata  = '0;
        stall  = 1'b0;
        if (state_q == ST_WAIT) begin
            sel_oh = slot_onehot(slot_q);
            io_sel = sel_oh;
            if (cnt_q == 4'd0) begin
                if (we_q) io_we = sel_oh;
                else      rdata = slot_rdata(slot_q);
            end else begin
                stall = 1'b1;
            end
        end else if (!is_io) begin
            ram_we = req_we;
            rdata  = ram_rdata;
        end else if (io_req) begin
            sel_oh = slot_onehot(slot_num);
            io_sel = sel_oh;
            if (WAIT_CYC == 0) begin
                // Zero wait states: request cycle is also the completion cycle.
                if (req_we) io_we = sel_oh;
                else        rdata = slot_rdata(slot_num);
            end else begin
                stall = 1'b1;
            end
        end
    end

`ifdef IO_BUS_ERR_EN
    logic              bus_err_q;
    logic [ADDR_W-1:0] fault_addr_q;

    // A new fault beats a simultaneous clear; the address is refreshed in
    // that case so software sees the fault that re-armed the flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_err_q    <= 1'b0;
            fault_addr_q <= '0;
        end else if (unmapped_req) begin
            bus_err_q <= 1'b1;
            if (!bus_err_q || err_clr) fault_addr_q <= addr;
        end else if (err_clr) begin
            bus_err_q <= 1'b0;
        end
    end

    assign bus_err    = bus_err_q;
    assign fault_addr = fault_addr_q;
`else
    logic unused_err;
    assign unused_err = err_clr | unmapped_req;
    assign bus_err    = 1'b0;
    assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_io_bus_decoder.sv
module tb_io_bus_decoder;

    localparam int W = 2;   // wait states of the main DUT; second DUT uses 0

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr;
    logic         we, re, err_clr;
    logic [31:0]  ram_rdata;
    logic [127:0] io_rdata;

    logic [31:0] w_ram_addr, z_ram_addr;
    logic        w_ram_we,   z_ram_we;
    logic [3:0]  w_io_sel,   z_io_sel;
    logic [3:0]  w_io_we,    z_io_we;
    logic [3:0]  w_io_off,   z_io_off;
    logic [31:0] w_rdata,    z_rdata;
    logic        w_stall,    z_stall;
    logic        w_bus_err,  z_bus_err;
    logic [31:0] w_fault,    z_fault;

    int checks   = 0;
    int failures = 0;

    logic        m_err;
    logic [31:0] m_fault;
    logic        rand_data;

    always #5 clk = ~clk;

    io_bus_decoder #(.WAIT_CYC(W)) dut_w (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .err_clr(err_clr),
        .ram_rdata(ram_rdata), .io_rdata(io_rdata),
        .ram_addr(w_ram_addr), .ram_we(w_ram_we), .io_sel(w_io_sel), .io_we(w_io_we),
        .io_off(w_io_off), .rdata(w_rdata), .stall(w_stall),
        .bus_err(w_bus_err), .fault_addr(w_fault)
    );

    io_bus_decoder #(.WAIT_CYC(0)) dut_z (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .err_clr(err_clr),
        .ram_rdata(ram_rdata), .io_rdata(io_rdata),
        .ram_addr(z_ram_addr), .ram_we(z_ram_we), .io_sel(z_io_sel), .io_we(z_io_we),
        .io_off(z_io_off), .rdata(z_rdata), .stall(z_stall),
        .bus_err(z_bus_err), .fault_addr(z_fault)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int slot_of(input logic [31:0] a);
        return int'((a >> 4) & 32'h3FFFF);
    endfunction

    function automatic bit is_mapped_req(input logic [31:0] a, input logic w, input logic r);
        return a[22] && (w || r) && (slot_of(a) < 4);
    endfunction

    // Expected outputs for cycle 'phase' (0 = request cycle) of an access
    // on a decoder with 'wc' wait states.
    task automatic expect_out(input logic [31:0] a, input logic w, input logic r,
                              input int phase, input int wc,
                              output logic e_ram_we, output logic [3:0] e_sel,
                              output logic [3:0] e_we, output logic [31:0] e_rd,
                              output logic e_stall);
        int s;
        s = slot_of(a);
        e_ram_we = 1'b0; e_sel = 4'd0; e_we = 4'd0; e_rd = 32'd0; e_stall = 1'b0;
        if (!a[22]) begin
            e_ram_we = w;
            e_rd     = ram_rdata;
        end else if (is_mapped_req(a, w, r)) begin
            e_sel   = 4'(1 << s);
            e_stall = (phase < wc);
            if (phase == wc) begin
                if (w) e_we = e_sel;
                else   e_rd = io_rdata[s*32 +: 32];
            end
        end
    endtask

    task automatic check_all(input int phase);
        logic erw; logic [3:0] es, ew; logic [31:0] ed; logic est;
        logic gw, gr;
        gw = we & ~rst;
        gr = re & ~rst;
        expect_out(addr, gw, gr, phase, W, erw, es, ew, ed, est);
        chk("w_ram_addr", w_ram_addr, addr);
        chk("w_ram_we",   w_ram_we,   erw);
        chk("w_io_sel",   w_io_sel,   es);
        chk("w_io_we",    w_io_we,    ew);
        chk("w_io_off",   w_io_off,   addr[3:0]);
        chk("w_rdata",    w_rdata,    ed);
        chk("w_stall",    w_stall,    est);
        chk("w_bus_err",  w_bus_err,  m_err);
        chk("w_fault",    w_fault,    m_fault);
        expect_out(addr, gw, gr, 0, 0, erw, es, ew, ed, est);
        chk("z_ram_addr", z_ram_addr, addr);
        chk("z_ram_we",   z_ram_we,   erw);
        chk("z_io_sel",   z_io_sel,   es);
        chk("z_io_we",    z_io_we,    ew);
        chk("z_io_off",   z_io_off,   addr[3:0]);
        chk("z_rdata",    z_rdata,    ed);
        chk("z_stall",    z_stall,    est);
        chk("z_bus_err",  z_bus_err,  m_err);
        chk("z_fault",    z_fault,    m_fault);
    endtask

    // Advance the error-flag model by one clock edge, then step the clock.
    task automatic next_cycle();
        if (rst) begin
            m_err   = 1'b0;
            m_fault = 32'd0;
        end
`ifdef IO_BUS_ERR_EN
        else if (addr[22] && (we || re) && (slot_of(addr) >= 4)) begin
            if (!m_err || err_clr) m_fault = addr;
            m_err = 1'b1;
        end else if (err_clr) begin
            m_err = 1'b0;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    // One complete access; mapped IO requests are held for the full latency.
    task automatic do_access(input logic [31:0] a, input logic w, input logic r, input logic clr);
        int n;
        n = is_mapped_req(a, w, r) ? W + 1 : 1;
        for (int i = 0; i < n; i++) begin
            addr    = a;
            we      = w;
            re      = r;
            err_clr = clr && (i == 0);
            if (rand_data) begin
                ram_rdata = $urandom;
                io_rdata  = {$urandom, $urandom, $urandom, $urandom};
            end
            #3;
            check_all(i);
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; addr = 32'd0; we = 1'b0; re = 1'b0; err_clr = 1'b0;
        ram_rdata = 32'd0; io_rdata = '0; rand_data = 1'b0;
        m_err = 1'b0; m_fault = 32'd0;
        #3;
        check_all(0);
        next_cycle();
        check_all(0);
        rst = 1'b0;
        next_cycle();

        // RAM write, then RAM read with data flowing through
        ram_rdata = 32'h1234_5678;
        do_access(32'h0000_0100, 1'b1, 1'b0, 1'b0);
        ram_rdata = 32'hCAFE_F00D;
        do_access(32'h0000_0104, 1'b0, 1'b1, 1'b0);

        // IO write slot 2, IO read slot 1, write slot 3
        io_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1111};
        do_access(32'h0040_0020, 1'b1, 1'b0, 1'b0);
        do_access(32'h0040_0010, 1'b0, 1'b1, 1'b0);
        do_access(32'h0040_0030, 1'b1, 1'b0, 1'b0);
        do_access(32'h0040_003C, 1'b1, 1'b1, 1'b0);

        // Unmapped accesses and error clear behaviour
        do_access(32'h0040_0050, 1'b1, 1'b0, 1'b0);
        do_access(32'h0040_0060, 1'b0, 1'b1, 1'b0);
        do_access(32'h0000_0000, 1'b0, 1'b0, 1'b1);
        do_access(32'h0000_0000, 1'b0, 1'b0, 1'b0);
        do_access(32'h0040_0070, 1'b1, 1'b0, 1'b1);
        do_access(32'h0040_0080, 1'b0, 1'b1, 1'b1);
        do_access(32'h0040_0090, 1'b0, 1'b1, 1'b0);
        do_access(32'h0040_0000, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a wait-state IO write to slot 0
        addr = 32'h0040_0000; we = 1'b1; re = 1'b0; err_clr = 1'b0;
        #3;
        check_all(0);
        next_cycle();
        #3;
        check_all(1);
        rst = 1'b1; we = 1'b0;
        m_err = 1'b0; m_fault = 32'd0;
        #1;
        check_all(0);
        next_cycle();
        check_all(0);
        rst = 1'b0;
        #3;
        check_all(0);
        next_cycle();
        check_all(0);
        next_cycle();
        do_access(32'h0040_0000, 1'b1, 1'b0, 1'b0);

        // Randomised traffic
        rand_data = 1'b1;
        for (int it = 0; it < 80; it++) begin
            logic [31:0] a;
            logic w, r, c;
            int kind;
            kind = $urandom_range(0, 4);
            w = 1'($urandom);
            r = 1'($urandom);
            c = ($urandom_range(0, 3) == 0);
            case (kind)
                0: a = $urandom & ~32'h0040_0000;
                1, 2: a = ($urandom & 32'hFF80_0000) | 32'h0040_0000 |
                          (32'($urandom_range(0, 3)) << 4) | ($urandom & 32'hF);
                3: a = ($urandom & 32'hFF80_0000) | 32'h0040_0000 |
                       (32'($urandom_range(4, 262143)) << 4) | ($urandom & 32'hF);
                default: begin
                    a = $urandom | 32'h0040_0000;
                    w = 1'b0;
                    r = 1'b0;
                end
            endcase
            do_access(a, w, r, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_decoder.md
# io_bus_decoder

Parametrised successor to the single-cycle IO/RAM decoder. It routes each core data access either to RAM or to one of `N_SLOTS` memory-mapped peripheral slots. IO accesses get configurable wait states, and the core is stalled while they are pending. It sits between the core's load/store port and the RAM and peripheral blocks, and is the single point of address decode for the data bus.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `N_SLOTS`, default 4: peripheral slot count, legal range 1..8.
- `IO_SEL_BIT`, default 22: address bit that selects the IO region (1 = IO, 0 = RAM).
- `SLOT_SHIFT`, default 4: each slot spans 2^`SLOT_SHIFT` bytes.
- `WAIT_CYC`, default 1: wait states per IO access, legal range 0..15.

Ports:
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `addr`  in  `ADDR_W`: access address. The core holds it stable while `stall`=1.
- `we`  in  1: store request.
- `re`  in  1: load request.
- `err_clr`  in  1: clears the sticky bus error.
- `ram_rdata`  in  `DATA_W`: RAM read data.
- `io_rdata`  in  `N_SLOTS`*`DATA_W`: per-slot read data; slot k is at bits [k*`DATA_W` +: `DATA_W`].
- `ram_addr`  out  `ADDR_W`: equal to `addr`.
- `ram_we`  out  1: RAM write enable.
- `io_sel`  out  `N_SLOTS`: one-hot slot select.
- `io_we`  out  `N_SLOTS`: one-hot slot write strobe.
- `io_off`  out  `SLOT_SHIFT`: register offset inside the slot, equal to `addr`[`SLOT_SHIFT`-1:0].
- `rdata`  out  `DATA_W`: load data returned to the core.
- `stall`  out  1: holds the core while an IO access is pending.
- `bus_err`  out  1: sticky unmapped-access flag.
- `fault_addr`  out  `ADDR_W`: address of the first unmapped access.

## Operation
Decode:
- RAM access: `addr`[`IO_SEL_BIT`]=0.
- IO access: `addr`[`IO_SEL_BIT`]=1.
- Slot number = `addr`[`IO_SEL_BIT`-1:`SLOT_SHIFT`].
- Unmapped: IO access with slot number ≥ `N_SLOTS`.

Request and data rules:
- A request is `we`|`re`. If both are set, it is a write and `re` is ignored.
- RAM access: purely combinational. `ram_we`=`we`, `rdata`=`ram_rdata`, `stall`=0, `io_sel`=0, `io_we`=0.

IO access FSM, states IDLE and WAIT, with a 4-bit down-counter `cnt`:
- IDLE, mapped IO request, `WAIT_CYC`=0: the access completes in the same cycle. State stays IDLE.
- IDLE, mapped IO request, `WAIT_CYC`>0:
  - Latch the slot number and `we`.
  - Load `cnt`=`WAIT_CYC`-1.
  - Assert `stall`=1 and go to WAIT.
- WAIT with `cnt`≠0: `stall`=1, decrement `cnt`.
- WAIT with `cnt`=0: this is the completion cycle. `stall`=0, go to IDLE next edge.
- While WAIT is active, slot and `we` come from the latched copies. Changes on `addr`/`we` are ignored.

IO output rules:
- `io_sel`: one-hot of the active slot on every cycle of a mapped IO access (request cycle through completion cycle). 0 otherwise.
- `io_we`: one-hot of the slot for exactly one cycle, the completion cycle, and only for writes.
- `rdata` in a load completion cycle: the selected slot's `io_rdata` slice. In all other IO cycles: 0.
- `ram_we`=0 for any IO access.

Unmapped access:
- No stall and no strobes: `io_sel`=0, `io_we`=0.
- `rdata`=0.
- Error handling depends on configuration (see below).

## Timing
- Reset values:
  - State IDLE, `cnt`=0.
  - `stall`=0, `io_we`=0, `io_sel`=0, `ram_we`=0.
  - `bus_err`=0, `fault_addr`=0.
- IO access latency is `WAIT_CYC`+1 cycles including the request cycle.
- `stall` is high for exactly `WAIT_CYC` cycles. The core advances on the first cycle with `stall`=0.
- Back-to-back IO accesses: a new request in the cycle after completion starts a fresh full-latency access.
- `rst` asserted mid-WAIT:
  - State goes to IDLE immediately (asynchronous) and `stall` drops.
  - No `io_we` is issued.
  - The aborted access is not resumed after reset releases.
- `bus_err` sets on the clock edge after the unmapped request, i.e. it is visible next cycle.
- `err_clr` is synchronous.
- `err_clr` and a new unmapped access in the same cycle: the set wins, `bus_err` stays 1, and `fault_addr` is updated to the new address.

## Configuration
Macro `IO_BUS_ERR_EN`:
- Defined:
  - An unmapped access sets `bus_err`=1 (sticky until `err_clr`).
  - `fault_addr` latches `addr` only when `bus_err` was 0 (first fault kept), except in the simultaneous clear case above.
- Undefined:
  - `bus_err` and `fault_addr` are tied to 0 and their registers are not built.
  - Unmapped writes are dropped silently and unmapped reads return 0.
  - `err_clr` is ignored.

## Test plan
Defaults unless stated: `ADDR_W`=32, `DATA_W`=32, `N_SLOTS`=4, `IO_SEL_BIT`=22, `SLOT_SHIFT`=4.

1. RAM write, `addr`=0x0000_0100, `we`=1 → `ram_we`=1 in the same cycle, `stall`=0, `io_sel`=0; `rdata` follows `ram_rdata`.
2. `WAIT_CYC`=2, IO write to `addr`=0x0040_0020 (slot 2) →
   - `stall`=1 in cycles 0–1, 0 in cycle 2.
   - `io_sel`=0b0100 in cycles 0–2.
   - `io_we`=0b0100 only in cycle 2.
   - `io_off`=0.
3. `WAIT_CYC`=2, IO read from 0x0040_0010, slot 1 `io_rdata`=0xDEADBEEF → `rdata`=0xDEADBEEF in cycle 2 with `stall`=0; `rdata`=0 in cycles 0–1; `io_we` never asserted.
4. Unmapped write to 0x0040_0050 (slot 5):
   - With `IO_BUS_ERR_EN`: no stall, `io_we`=0; next cycle `bus_err`=1 and `fault_addr`=0x0040_0050.
   - Then unmapped 0x0040_0060 → `fault_addr` unchanged.
   - Then `err_clr` pulse → `bus_err`=0.
   - Without the macro: `bus_err` stays 0 throughout.
5. `WAIT_CYC`=3, IO write to slot 0, `rst` pulsed in cycle 1 → `stall` drops during reset and no `io_we` appears. After release, a new IO write takes 4 cycles with `io_we` in its last cycle.
6. `WAIT_CYC`=0, IO write to slot 3 (0x0040_0030) → `io_we`=0b1000 in the same cycle; `stall` never asserts.
